pe_scheduler: RTL and testbench

Layer-level job scheduler for the sparse-convolution PE array. It accepts compressed tile jobs (IA/W descriptor words) from the fetch unit over a valid/ready stream and dispatches each to a free PE with a one-cycle start pulse. It tracks each PE's finish and arbitrates the single shared feature-map writeback port among finished PEs. It raises a done pulse when all jobs of the layer have been written back.

---
 rtl/pe_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/pe_scheduler.sv | 159 +++++++++++++++
 tb/tb_pe_scheduler.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg: shared types and default sizing for the
// sparse-convolution PE job scheduler.
package pe_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } top_state_e;

    typedef enum logic [1:0] {
        P_FREE,
        P_BUSY,
        P_WB
    } pe_state_e;

    localparam int DEF_NUM_PE = 4;
    localparam int DEF_JOB_W  = 64;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among requesters, priority starting
// just after the last advanced grant.
module rr_arbiter
    import pe_sched_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr_q + W'(i);
            if (i_req[cand]) begin
                o_idx = cand;
                o_any = 1'b1;
            end
        end
        if (o_any) o_gnt[o_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else if (i_adv && o_any) begin
            ptr_q <= o_idx + W'(1);
        end
    end

endmodule

// File: rtl/pe_scheduler.sv
// pe_scheduler: dispatches tile jobs to free PEs and arbitrates
// the shared writeback port among finished PEs.
module pe_scheduler
    import pe_sched_pkg::*;
#(
    parameter  int NUM_PE = DEF_NUM_PE,
    parameter  int JOB_W  = DEF_JOB_W,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int IDX_W  = $clog2(NUM_PE)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_jobs,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [JOB_W-1:0]  i_job_data,
    output logic [NUM_PE-1:0] o_pe_start,
    output logic [JOB_W-1:0]  o_pe_job,
    input  logic [NUM_PE-1:0] i_pe_finish,
    output logic              o_wb_valid,
    output logic [IDX_W-1:0]  o_wb_pe_idx,
    input  logic              i_wb_done,
    output logic              o_busy,
    output logic              o_layer_done,
    output logic              o_err
);

    top_state_e state_q, state_d;
    pe_state_e  pe_q [NUM_PE];

    logic [CNT_W-1:0]  num_q, disp_q, comp_q;
    logic [NUM_PE-1:0] start_q, wb_req, arb_gnt, wb_gnt_q;
    logic [JOB_W-1:0]  job_q;
    logic [IDX_W-1:0]  free_idx, arb_idx, wb_idx_q;
    logic run, any_free, hs, wb_ack, issue, bad, start_acc;
    logic arb_any, wb_valid_q, err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (i_start) state_d = S_RUN;
            S_RUN: begin
                if (comp_q + CNT_W'(wb_ack) == num_q)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run          = 1'b0;
        o_busy       = 1'b1;
        o_layer_done = 1'b0;
        unique case (state_q)
            S_IDLE:  o_busy = 1'b0;
            S_RUN:   run = 1'b1;
            S_DONE:  o_layer_done = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        wb_req   = '0;
        bad      = 1'b0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (pe_q[i] == P_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            wb_req[i] = (pe_q[i] == P_WB);
            // A PE still showing its start pulse cannot finish yet.
            if (i_pe_finish[i] && (pe_q[i] != P_BUSY || start_q[i]))
                bad = 1'b1;
        end
    end

    assign start_acc   = (state_q == S_IDLE) && i_start;
    assign o_job_ready = run && any_free && (disp_q < num_q);
    assign hs          = i_job_valid && o_job_ready;
    assign wb_ack      = wb_valid_q && i_wb_done;
    assign issue       = !wb_valid_q && arb_any;

    rr_arbiter #(.N(NUM_PE)) u_wb_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (wb_req),
        .i_adv   (issue),
        .o_gnt   (arb_gnt),
        .o_idx   (arb_idx),
        .o_any   (arb_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PE; i++) pe_q[i] <= P_FREE;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (i_pe_finish[i] && pe_q[i] == P_BUSY && !start_q[i])
                    pe_q[i] <= P_WB;
                if (hs && free_idx == IDX_W'(i))
                    pe_q[i] <= P_BUSY;
                if (wb_ack && wb_gnt_q[i])
                    pe_q[i] <= P_FREE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_q      <= '0;
            disp_q     <= '0;
            comp_q     <= '0;
            start_q    <= '0;
            job_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_gnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start_acc) begin
                num_q  <= i_num_jobs;
                disp_q <= '0;
                comp_q <= '0;
            end else begin
                if (hs)     disp_q <= disp_q + CNT_W'(1);
                if (wb_ack) comp_q <= comp_q + CNT_W'(1);
            end
            start_q <= '0;
            if (hs) begin
                start_q[free_idx] <= 1'b1;
                job_q             <= i_job_data;
            end
            if (wb_ack) begin
                wb_valid_q <= 1'b0;
            end else if (issue) begin
                wb_valid_q <= 1'b1;
                wb_idx_q   <= arb_idx;
                wb_gnt_q   <= arb_gnt;
            end
            err_q <= err_q | bad;
        end
    end

    assign o_pe_start  = start_q;
    assign o_pe_job    = job_q;
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_pe_idx = wb_idx_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_pe_scheduler.sv
// tb_pe_scheduler: directed scenarios plus randomized layers checked
// against a cycle-level behavioural model of the scheduler rules.
`timescale 1ns/1ps
module tb_pe_scheduler;

    localparam int NP = 4;
    localparam int JW = 64;
    localparam int CW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_jobs = '0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [JW-1:0] job_data = '0;
    logic [NP-1:0] pe_start;
    logic [JW-1:0] pe_job;
    logic [NP-1:0] pe_finish = '0;
    logic          wb_valid;
    logic [IW-1:0] wb_idx;
    logic          wb_done = 1'b0;
    logic          busy, layer_done, err;

    int errs = 0;
    int checks = 0;

    // Model: PE status 0=free 1=busy 2=writeback; layer 0=idle 1=run 2=done
    int            m_pe [NP];
    int            m_st, m_disp, m_comp, m_num, m_rr;
    bit            m_wbv, m_err;
    logic [IW-1:0] m_wbidx;
    logic [NP-1:0] m_start;
    logic [JW-1:0] m_job;
    int            lat [NP];
    int            n_starts;

    always #5 clk = ~clk;

    pe_scheduler #(.NUM_PE(NP), .JOB_W(JW), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_num_jobs   (num_jobs),
        .i_job_valid  (job_valid),
        .o_job_ready  (job_ready),
        .i_job_data   (job_data),
        .o_pe_start   (pe_start),
        .o_pe_job     (pe_job),
        .i_pe_finish  (pe_finish),
        .o_wb_valid   (wb_valid),
        .o_wb_pe_idx  (wb_idx),
        .i_wb_done    (wb_done),
        .o_busy       (busy),
        .o_layer_done (layer_done),
        .o_err        (err)
    );

    function automatic bit exp_ready();
        bit fr = 0;
        for (int p = 0; p < NP; p++) if (m_pe[p] == 0) fr = 1;
        return (m_st == 1) && fr && (m_disp < m_num);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_pe[p] = 0;
        m_st = 0; m_disp = 0; m_comp = 0; m_num = 0; m_rr = 0;
        m_wbv = 0; m_err = 0; m_wbidx = '0; m_start = '0; m_job = '0;
    endtask

    task automatic model_update();
        int  npe [NP];
        int  k, g, p;
        bit  hs, ack, bad;
        hs  = job_valid && exp_ready();
        ack = m_wbv && wb_done;
        k = -1;
        for (int i = 0; i < NP; i++) if (k < 0 && m_pe[i] == 0) k = i;
        npe = m_pe;
        bad = 0;
        for (int i = 0; i < NP; i++) begin
            if (pe_finish[i]) begin
                if (m_pe[i] == 1 && !m_start[i]) npe[i] = 2;
                else bad = 1;
            end
        end
        if (hs) npe[k] = 1;
        if (ack) npe[m_wbidx] = 0;
        g = -1;
        if (!m_wbv) begin
            for (int i = 0; i < NP; i++) begin
                p = (m_rr + i) % NP;
                if (g < 0 && m_pe[p] == 2) g = p;
            end
        end
        if (m_st == 0) begin
            if (start) begin
                m_st = 1; m_num = int'(num_jobs); m_disp = 0; m_comp = 0;
            end
        end else if (m_st == 1) begin
            if (m_comp + int'(ack) == m_num) m_st = 2;
        end else begin
            m_st = 0;
        end
        m_start = '0;
        if (hs) begin
            m_disp++; m_job = job_data; m_start[k] = 1'b1;
        end
        if (ack) begin
            m_comp++; m_wbv = 0;
        end else if (g >= 0) begin
            m_wbv = 1; m_wbidx = IW'(g); m_rr = (g + 1) % NP;
        end
        m_err = m_err | bad;
        m_pe = npe;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; job_valid = 0; pe_finish = '0; wb_done = 0;
    endtask

    // Legal random PE/fetch behaviour, every cycle compared to the model.
    task automatic drive_random(input int max_cyc);
        logic [NP+IW+4:0] got, expv;
        bit done_seen = 0;
        n_starts = 0;
        for (int p = 0; p < NP; p++) lat[p] = 0;
        for (int c = 0; c < max_cyc && !done_seen; c++) begin
            job_valid = ($urandom_range(0, 9) < 7);
            job_data  = {$urandom, $urandom};
            wb_done   = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 15) == 0);
            num_jobs  = CW'($urandom_range(0, 20));
            pe_finish = '0;
            for (int p = 0; p < NP; p++) begin
                if (m_start[p]) lat[p] = $urandom_range(0, 3);
                else if (m_pe[p] == 1) begin
                    if (lat[p] == 0) pe_finish[p] = 1'b1;
                    else lat[p]--;
                end
            end
            cyc();
            got  = {job_ready, pe_start, wb_valid, wb_idx,
                    busy, layer_done, err};
            expv = {exp_ready(), m_start, m_wbv, m_wbidx,
                    m_st != 0, m_st == 2, m_err};
            checks++;
            if (got !== expv) begin
                errs++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b",
                         $time, got, expv);
            end
            if (m_start != '0) begin
                checks++;
                if (pe_job !== m_job) begin
                    errs++;
                    $display("FAIL pe_job t=%0t got=%h exp=%h",
                             $time, pe_job, m_job);
                end
            end
            if (pe_start != '0) n_starts++;
            if (m_st == 2) done_seen = 1;
        end
        clear_inputs();
    endtask

    task automatic finish_layer(input int max_cyc);
        drive_random(max_cyc);
        checks++;
        if (layer_done !== 1'b1) begin
            errs++;
            $display("FAIL layer_done_timeout got=%b exp=1", layer_done);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL busy_after_done got=%b exp=0", busy);
        end
    endtask

    task automatic run_layer(input int n);
        start = 1; num_jobs = CW'(n);
        cyc();
        start = 0;
        finish_layer(n * 40 + 60);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) cyc();
        checks++;
        if ({job_ready, pe_start, pe_job, wb_valid, wb_idx,
             busy, layer_done, err} !== '0) begin
            errs++;
            $display("FAIL reset_vals got=%b %b %h %b %b %b %b %b exp=0",
                     job_ready, pe_start, pe_job, wb_valid, wb_idx,
                     busy, layer_done, err);
        end
        rst_n = 1;
        cyc();
    endtask

    task automatic test_basic();
        logic [NP-1:0] e;
        logic [JW-1:0] d;
        start = 1; num_jobs = 4;
        cyc();
        start = 0;
        checks++;
        if (job_ready !== 1'b1) begin
            errs++; $display("FAIL basic_ready got=%b exp=1", job_ready);
        end
        job_valid = 1;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            job_data = d;
            cyc();
            e = '0; e[i] = 1'b1;
            checks++;
            if (pe_start !== e || pe_job !== d) begin
                errs++;
                $display("FAIL basic_start%0d got=%b/%h exp=%b/%h",
                         i, pe_start, pe_job, e, d);
            end
            checks++;
            if (job_ready !== (i < 3)) begin
                errs++;
                $display("FAIL basic_ready%0d got=%b exp=%b",
                         i, job_ready, (i < 3));
            end
        end
        job_valid = 0;
        cyc();
        pe_finish = 4'hF;
        cyc();
        pe_finish = '0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errs++; $display("FAIL basic_wb_early got=%b exp=0", wb_valid);
        end
        for (int g = 0; g < 4; g++) begin
            cyc();
            checks++;
            if (wb_valid !== 1'b1 || wb_idx !== IW'(g)) begin
                errs++;
                $display("FAIL basic_grant%0d got=%b/%0d exp=1/%0d",
                         g, wb_valid, wb_idx, g);
            end
            wb_done = 1;
            cyc();
            wb_done = 0;
            checks++;
            if (wb_valid !== 1'b0 || layer_done !== (g == 3)) begin
                errs++;
                $display("FAIL basic_ack%0d got=%b/%b exp=0/%b",
                         g, wb_valid, layer_done, (g == 3));
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || layer_done !== 1'b0) begin
            errs++;
            $display("FAIL basic_idle got=%b/%b exp=0/0", busy, layer_done);
        end
    endtask

    task automatic test_zero_jobs();
        start = 1; num_jobs = 0;
        cyc();
        start = 0;
        checks++;
        if (layer_done !== 1'b0 || pe_start !== '0) begin
            errs++;
            $display("FAIL zero_c1 got=%b/%b exp=0/0", layer_done, pe_start);
        end
        cyc();
        checks++;
        if (layer_done !== 1'b1 || pe_start !== '0) begin
            errs++;
            $display("FAIL zero_c2 got=%b/%b exp=1/0", layer_done, pe_start);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL zero_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_refill();
        logic [NP-1:0] e;
        start = 1; num_jobs = 9;
        cyc();
        start = 0;
        job_valid = 1;
        for (int i = 0; i < 4; i++) begin
            job_data = {$urandom, $urandom};
            cyc();
            e = '0; e[i] = 1'b1;
            checks++;
            if (pe_start !== e) begin
                errs++;
                $display("FAIL refill_start%0d got=%b exp=%b", i, pe_start, e);
            end
        end
        checks++;
        if (job_ready !== 1'b0) begin
            errs++; $display("FAIL refill_full got=%b exp=0", job_ready);
        end
        pe_finish = 4'b0100;
        cyc();
        pe_finish = '0;
        cyc();
        checks++;
        if (wb_valid !== 1'b1 || wb_idx !== 2'd2) begin
            errs++;
            $display("FAIL refill_grant got=%b/%0d exp=1/2", wb_valid, wb_idx);
        end
        wb_done = 1;
        cyc();
        wb_done = 0;
        checks++;
        if (job_ready !== 1'b1) begin
            errs++; $display("FAIL refill_ready got=%b exp=1", job_ready);
        end
        cyc();
        checks++;
        if (pe_start !== 4'b0100) begin
            errs++; $display("FAIL refill_pe2 got=%b exp=0100", pe_start);
        end
        finish_layer(500);
        checks++;
        if (5 + n_starts !== 9) begin
            errs++;
            $display("FAIL refill_total got=%0d exp=9", 5 + n_starts);
        end
    endtask

    task automatic test_rr();
        start = 1; num_jobs = 5;
        cyc();
        start = 0;
        job_valid = 1;
        repeat (4) cyc();
        job_valid = 0;
        cyc();
        pe_finish = 4'b0010;
        cyc();
        pe_finish = '0;
        cyc();
        checks++;
        if (wb_valid !== 1'b1 || wb_idx !== 2'd1) begin
            errs++;
            $display("FAIL rr_first got=%b/%0d exp=1/1", wb_valid, wb_idx);
        end
        wb_done = 1;
        cyc();
        wb_done = 0;
        job_valid = 1;
        cyc();
        job_valid = 0;
        checks++;
        if (pe_start !== 4'b0010) begin
            errs++; $display("FAIL rr_redisp got=%b exp=0010", pe_start);
        end
        cyc();
        pe_finish = 4'b1010;
        cyc();
        pe_finish = '0;
        cyc();
        checks++;
        if (wb_valid !== 1'b1 || wb_idx !== 2'd3) begin
            errs++;
            $display("FAIL rr_grant3 got=%b/%0d exp=1/3", wb_valid, wb_idx);
        end
        wb_done = 1;
        cyc();
        wb_done = 0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errs++; $display("FAIL rr_drop got=%b exp=0", wb_valid);
        end
        cyc();
        checks++;
        if (wb_valid !== 1'b1 || wb_idx !== 2'd1) begin
            errs++;
            $display("FAIL rr_grant1 got=%b/%0d exp=1/1", wb_valid, wb_idx);
        end
        finish_layer(300);
    endtask

    task automatic test_err();
        start = 1; num_jobs = 2;
        cyc();
        start = 0;
        pe_finish = 4'b0001;
        cyc();
        pe_finish = '0;
        checks++;
        if (err !== 1'b1) begin
            errs++; $display("FAIL err_set got=%b exp=1", err);
        end
        finish_layer(300);
        checks++;
        if (err !== 1'b1) begin
            errs++; $display("FAIL err_sticky got=%b exp=1", err);
        end
    endtask

    task automatic test_random_layers();
        for (int l = 0; l < 6; l++) run_layer($urandom_range(0, 14));
    endtask

    task automatic test_reset_mid();
        start = 1; num_jobs = 6;
        cyc();
        start = 0;
        job_valid = 1;
        repeat (3) cyc();
        job_valid = 0;
        cyc();
        pe_finish = 4'b0001;
        cyc();
        pe_finish = '0;
        cyc();
        checks++;
        if (wb_valid !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_pre got=%b/%b exp=1/1", wb_valid, busy);
        end
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({job_ready, pe_start, pe_job, wb_valid, wb_idx,
             busy, layer_done, err} !== '0) begin
            errs++;
            $display("FAIL mid_reset got=%b %b %h %b %b %b %b %b exp=0",
                     job_ready, pe_start, pe_job, wb_valid, wb_idx,
                     busy, layer_done, err);
        end
        @(negedge clk);
        cyc();
        rst_n = 1;
        cyc();
        run_layer(7);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_zero_jobs();
        test_refill();
        test_rr();
        test_err();
        test_random_layers();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
